// File: rtl/request_encoder_seq_pkg.sv
// rtl/request_encoder_seq_pkg.sv - shared state encodings and default widths for request_encoder_seq
package request_encoder_seq_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int CODE_W_DEF = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/request_encoder_seq_priority_encoder_comb.sv
// rtl/request_encoder_seq_priority_encoder_comb.sv - combinational priority encoder, highest set bit wins
module priority_encoder_comb #(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2
) (
  input  logic [N_IN-1:0]   pending,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan: a later (higher) set bit overrides any lower one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (pending[i]) begin
        idx = CODE_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_encoder_seq.sv
// rtl/request_encoder_seq.sv - captures a request vector and issues one code per handshake, highest priority first
module request_encoder_seq
  import request_encoder_seq_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   req_in,
  input  logic              req_load,
  output logic              load_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              done
);

  logic [0:0]        r_state;
  logic [N_IN-1:0]   r_pending;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_done;
  logic              r_load_ready;

  logic              w_accept;
  logic [N_IN-1:0]   w_pending_next;
  logic [N_IN-1:0]   w_enc_in;
  logic [CODE_W-1:0] w_enc_idx;
  logic              w_enc_any;

  assign w_accept       = r_valid && code_ready;
  assign w_pending_next = r_pending & ~(N_IN'(1) << r_code);

  // One encoder serves both the first code of a batch and every follow-on code.
  assign w_enc_in = (r_state == ST_IDLE) ? req_in : w_pending_next;

  priority_encoder_comb #(
    .N_IN   (N_IN),
    .CODE_W (CODE_W)
  ) u_prio (
    .pending (w_enc_in),
    .idx     (w_enc_idx),
    .any     (w_enc_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_code       <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_load && w_enc_any) begin
            r_pending    <= req_in;
            r_code       <= w_enc_idx;
            r_valid      <= 1'b1;
            r_load_ready <= 1'b0;
            r_state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_accept) begin
            r_pending <= w_pending_next;
            if (w_enc_any) begin
              r_code <= w_enc_idx;
            end else begin
              // Last bit served: code keeps its final value.
              r_valid      <= 1'b0;
              r_done       <= 1'b1;
              r_load_ready <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_pending    <= '0;
          r_valid      <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign code       = r_code;
  assign code_valid = r_valid;
  assign done       = r_done;

endmodule

// File: doc/request_encoder_seq.md
Name: request_encoder_seq

Overview:
- Sequential 4-to-2 priority encoder; the inverse of the team's 2-to-4 decoder (inputs A,B; output Y[3:0], where Y index = {A,B}).
- Captures a request vector, then issues one 2-bit code per accepted handshake, highest-priority bit first, until every set bit has been served.
- Its code output feeds the decoder directly, so decoder Y reproduces each served request as a one-hot.

Parameters:
- N_IN, 4, width of the request vector.
- CODE_W, 2, code width; must equal clog2(N_IN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_in  input  N_IN  request vector; bit i requests code i.
- req_load  input  1  capture strobe for req_in.
- load_ready  output  1  block can accept req_load.
- code  output  CODE_W  encoded index; code[1] drives decoder A, code[0] drives decoder B.
- code_valid  output  1  code is meaningful.
- code_ready  input  1  consumer accepts code this cycle.
- done  output  1  one-cycle pulse after the last code of a batch is accepted.

Behaviour:
- Reset (sync, active-high, overrides every other input):
  - state=IDLE, pending=0, code=0, code_valid=0, done=0, load_ready=1.
  - A reset asserted mid-batch discards all pending requests.
- States: IDLE and EMIT, held in a registered state variable. All outputs are registered.
- IDLE:
  - load_ready=1, code_valid=0.
  - req_load=1 with req_in!=0: pending<=req_in; next cycle state=EMIT and code_valid=1. Latency from load to valid is 1 cycle.
  - req_load=1 with req_in==0: ignored; stay in IDLE; no outputs change.
- EMIT:
  - load_ready=0, code_valid=1.
  - code = index of the highest set bit of pending (bit N_IN-1 has highest priority).
  - Accept = code_valid && code_ready. On accept, the served bit is cleared from pending.
  - If bits remain after an accept, the next code is presented the following cycle. With code_ready held high, one code is issued per cycle.
  - If the cleared bit was the last one: next cycle state=IDLE, code_valid=0, done=1 for exactly one cycle, load_ready=1, code holds its last value.
- Hold rule: while code_valid=1 and code_ready=0, code and pending must not change.
- req_load while load_ready=0 (including the cycle of the final accept) is ignored; there is no merging into pending.
- code_ready while code_valid=0 has no effect.
- No wrap-around: each batch serves each set bit exactly once, N_IN codes at most.
- Width rule: code is zero-extended binary, CODE_W bits. Out-of-range indices are impossible by construction.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=1'b0, ST_EMIT=1'b1
  - default N_IN=4 and CODE_W=2
- Sub-module priority_encoder_comb: purely combinational; pending[N_IN-1:0] -> idx[CODE_W-1:0], any.
- The top block holds the FSM, the pending register and the handshake.

Test Plan:
- Reset: assert reset for 2 cycles -> code=00, code_valid=0, done=0, load_ready=1. Then load 4'b1111 with reset high -> still IDLE after release.
- Basic batch: load req_in=4'b1010, code_ready=1 -> next cycle code=11, valid=1. Following cycle code=01. Then valid=0, done=1 for 1 cycle, load_ready=1.
- Backpressure: load 4'b1111, code_ready=0 for 3 cycles -> code held at 11, pending unchanged. Then code_ready=1 -> codes 11,10,01,00 on consecutive cycles, then done pulse.
- Empty load and load-while-busy:
  - load 4'b0000 -> stays IDLE, valid=0.
  - load 4'b0110, then load 4'b1001 during EMIT -> only codes 10,01 issued; the second load is ignored.
- Mid-batch reset: load 4'b1011, accept one code (11), assert reset -> next cycle valid=0, pending=0, load_ready=1, no done pulse.
- Loopback with decoder: connect code[1]->A and code[0]->B. Load 4'b0101 -> decoder Y equals 0100 then 0001 on the respective accept cycles.
